// File: rtl/lab6_pipe_reg.sv
// rtl/lab6_pipe_reg.sv - valid/ready register pipeline with bubble collapse
// Optional synchronous flush input clr is compiled in when LAB6_PIPE_CLR_EN is defined.
module lab6_pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
`ifdef LAB6_PIPE_CLR_EN
  input  logic                         clr,
`endif
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] r;
  logic [WIDTH-1:0] d [DEPTH];
  logic             flush;
  logic             accept;
  logic             drain;
  logic             chain;

`ifdef LAB6_PIPE_CLR_EN
  assign flush = clr;
`else
  assign flush = 1'b0;
`endif

  // A stage is ready if it or any stage downstream of it has a hole, or the sink takes a beat.
  always_comb begin
    chain = out_ready;
    r     = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      chain = chain || !v[i];
      r[i]  = chain;
    end
  end

  assign in_ready  = r[0] && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign drain     = out_valid && out_ready;
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v     <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else if (flush) begin
      v     <= '0;
      count <= '0;
    end else begin
      if (r[0]) begin
        v[0] <= accept;
        if (accept) d[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (r[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
      count <= count + CW'(accept) - CW'(drain);
    end
  end

endmodule

// File: tb/tb_lab6_pipe_reg.sv
// tb/tb_lab6_pipe_reg.sv - directed self-checking bench for lab6_pipe_reg (WIDTH=8, DEPTH=4)
module tb_lab6_pipe_reg;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] count;
  logic       empty;
  logic       full;
`ifdef LAB6_PIPE_CLR_EN
  logic       clr;
`endif

  int total;
  int bad;
  int nxt;
  int acc;
  logic [7:0] got [$];

  lab6_pipe_reg #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
`ifdef LAB6_PIPE_CLR_EN
    .clr       (clr),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
`ifdef LAB6_PIPE_CLR_EN
    clr = 1'b0;
`endif
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_in_ready", in_ready, 1);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // latency: beat accepted at cycle 0 appears at cycle 4
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    #1 check("lat_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("lat_c1_valid", out_valid, 0);
    check("lat_c1_count", count, 1);
    tick(); tick();
    check("lat_c3_valid", out_valid, 0);
    tick();
    check("lat_c4_valid", out_valid, 1);
    check("lat_c4_data", out_data, 8'hA5);
    tick();
    check("lat_drain_count", count, 0);
    check("lat_drain_empty", empty, 1);
    check("lat_drain_valid", out_valid, 0);

    // backpressure: only 4 of 6 beats fit
    out_ready = 1'b0; nxt = 1; acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_data = nxt[7:0];
      #1;
      if (in_ready) begin acc++; nxt++; end
      tick();
    end
    check("bp_accepted", acc, 4);
    check("bp_full", full, 1);
    check("bp_in_ready", in_ready, 0);
    check("bp_count", count, 4);
    check("bp_hold_data", out_data, 8'h01);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 6; c++) begin
      in_valid = (nxt <= 6); in_data = nxt[7:0];
      #1;
      if (out_valid) got.push_back(out_data);
      if (in_valid && in_ready) nxt++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_out_count", got.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < got.size()) check($sformatf("bp_order_%0d", k), got[k], k + 1);
    end
    check("bp_final_empty", empty, 1);

    // full throughput: accept and drain every cycle while full
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'h10 + k[7:0];
      tick();
    end
    check("tp_full", full, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = 8'h14 + k[7:0];
      #1;
      check($sformatf("tp_in_ready_%0d", k), in_ready, 1);
      check($sformatf("tp_count_%0d", k), count, 4);
      check($sformatf("tp_out_%0d", k), {out_valid, out_data}, {1'b1, 8'h10 + k[7:0]});
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("tp_drained", empty, 1);

    // bubble collapse: two beats separated by a gap pack at the output end
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h77; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h88; tick();
    in_valid = 1'b0; tick(); tick(); tick();
    check("bub_count", count, 2);
    check("bub_stages", dut.v, 4'b1100);
    check("bub_out_data", out_data, 8'h77);
    check("bub_stage2", dut.d[2], 8'h88);

    // a third beat, then reset asserted between clock edges
    in_valid = 1'b1; in_data = 8'h99; tick();
    in_valid = 1'b0;
    check("mid_count3", count, 3);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    tick();
    rstn = 1'b1;
    tick();

`ifdef LAB6_PIPE_CLR_EN
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'h40 + k[7:0];
      tick();
    end
    check("clr_pre_count", count, 3);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1 check("clr_in_ready", in_ready, 0);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);
    check("clr_out_valid", out_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
